// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared CDB widths and result/broadcast record types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int c_NUM_FU = 3;
    localparam int c_TAG_W  = 4;
    localparam int c_DATA_W = 32;

    typedef struct packed {
        logic [c_TAG_W-1:0]  rob_tag;
        logic [c_DATA_W-1:0] value;
    } CDB_DATA;

    typedef struct packed {
        logic                valid;
        logic [c_TAG_W-1:0]  rob_tag;
        logic [c_DATA_W-1:0] value;
    } FU_RESULT;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Functional-unit result ports and CDB broadcast bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = c_NUM_FU
);

    logic [NUM_FU-1:0]               fu_valid;
    logic [NUM_FU-1:0][c_TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0][c_DATA_W-1:0] fu_value;
    logic [NUM_FU-1:0]               fu_ready;
    CDB_DATA                         cdb;
    logic [NUM_FU-1:0]               cdb_grant;

    modport master (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb, cdb_grant
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready, cdb, cdb_grant
    );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker; one-hot grant from ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [N-1:0]     grant
);

    int               w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = int'(ptr) + off;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  Module      : cdb_arbiter
//  Description : One-entry result slot per unit, round-robin onto registered CDB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = c_NUM_FU,
    parameter int TAG_W  = c_TAG_W,
    parameter int DATA_W = c_DATA_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       flush,
    cdb_arbiter_if.slave    bus
);

    localparam int c_PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    FU_RESULT                 r_slot [NUM_FU];
    logic [c_PTR_W-1:0]       r_rr_ptr;
    CDB_DATA                  r_cdb;
    logic [NUM_FU-1:0]        r_cdb_grant;

    logic [NUM_FU-1:0]        w_req;
    logic [NUM_FU-1:0]        w_grant;
    logic [NUM_FU-1:0]        w_load;
    logic [c_PTR_W-1:0]       w_gidx;
    logic [c_PTR_W-1:0]       w_ptr_next;
    logic [TAG_W-1:0]         w_sel_tag;
    logic [DATA_W-1:0]        w_sel_val;

    rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    // A slot being granted this cycle can take a new result at the same edge.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot_ctrl
        assign w_req[i]        = r_slot[i].valid;
        assign bus.fu_ready[i] = reset && !flush && (!r_slot[i].valid || w_grant[i]);
        assign w_load[i]       = bus.fu_valid[i] && bus.fu_ready[i] && (bus.fu_tag[i] != '0);
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_grant[i]) begin
                w_gidx = c_PTR_W'(i);
            end
        end
        w_ptr_next = (w_gidx == c_PTR_W'(NUM_FU - 1)) ? '0 : w_gidx + 1'b1;
        w_sel_tag  = r_slot[w_gidx].rob_tag;
        w_sel_val  = r_slot[w_gidx].value;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_slot[i] <= '0;
            end
            r_cdb       <= '0;
            r_cdb_grant <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            // Pointer deliberately survives a flush so fairness history is kept.
            for (int i = 0; i < NUM_FU; i++) begin
                r_slot[i] <= '0;
            end
            r_cdb       <= '0;
            r_cdb_grant <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_load[i]) begin
                    r_slot[i] <= {1'b1, bus.fu_tag[i], bus.fu_value[i]};
                end else if (w_grant[i]) begin
                    r_slot[i].valid <= 1'b0;
                end
            end
            if (|w_grant) begin
                r_cdb       <= {w_sel_tag, w_sel_val};
                r_cdb_grant <= w_grant;
                r_rr_ptr    <= w_ptr_next;
            end else begin
                r_cdb       <= '0;
                r_cdb_grant <= '0;
            end
        end
    end

    assign bus.cdb       = r_cdb;
    assign bus.cdb_grant = r_cdb_grant;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Scoreboard bench for cdb_arbiter against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(
        .NUM_FU (N),
        .TAG_W  (c_TAG_W),
        .DATA_W (c_DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [2:0]  grant;
    } exp_t;

    exp_t        sb [$];
    logic [35:0] pend [N][$];
    int          checks = 0;
    int          errors = 0;

    // Reference: each unit owns at most one held result; the oldest-pointer
    // rotation decides who broadcasts next.
    bit          m_v   [N];
    logic [3:0]  m_tag [N];
    logic [31:0] m_val [N];
    int          m_ptr = 0;

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int   w;
        exp_t e;
        bit   rdy [N];
        w = m_winner();
        e = '{tag: 4'd0, val: 32'd0, grant: 3'd0};
        if (!reset) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_ptr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = !m_v[i] || (w == i);
            if (w >= 0) begin
                e.tag   = m_tag[w];
                e.val   = m_val[w];
                e.grant = 3'(1 << w);
                m_v[w]  = 1'b0;
                m_ptr   = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.fu_valid[i] && rdy[i] && bus.fu_tag[i] != 4'd0) begin
                    m_v[i]   = 1'b1;
                    m_tag[i] = bus.fu_tag[i];
                    m_val[i] = bus.fu_value[i];
                end
            end
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        int   w;
        logic exp_rdy;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t: cdb tag=%0d but nothing expected", $time, bus.cdb.rob_tag);
        end else begin
            e = sb.pop_front();
            if (bus.cdb.rob_tag !== e.tag || bus.cdb.value !== e.val || bus.cdb_grant !== e.grant) begin
                errors++;
                $display("FAIL cdb at %0t: got tag=%0d val=%0h grant=%b, expected tag=%0d val=%0h grant=%b",
                         $time, bus.cdb.rob_tag, bus.cdb.value, bus.cdb_grant, e.tag, e.val, e.grant);
            end
        end
        w = m_winner();
        for (int i = 0; i < N; i++) begin
            exp_rdy = reset && !flush && (!m_v[i] || w == i);
            checks++;
            if (bus.fu_ready[i] !== exp_rdy) begin
                errors++;
                $display("FAIL fu_ready[%0d] at %0t: got %b, expected %b", i, $time, bus.fu_ready[i], exp_rdy);
            end
        end
    end

    // A presentation is retired once accepted, or when reset/flush discards it.
    task automatic tick();
        bit          cons [N];
        logic [35:0] p;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            cons[i] = bus.fu_valid[i] && (bus.fu_ready[i] || flush || !reset);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (cons[i]) bus.fu_valid[i] = 1'b0;
            if (!bus.fu_valid[i] && pend[i].size() > 0) begin
                p                = pend[i].pop_front();
                bus.fu_valid[i]  = 1'b1;
                bus.fu_tag[i]    = p[35:32];
                bus.fu_value[i]  = p[31:0];
            end
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push(input int u, input logic [3:0] tag, input logic [31:0] val);
        pend[u].push_back({tag, val});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_value = '0;
        drain(3);
        reset = 1'b1;
        drain(2);

        // single result
        push(0, 4'd1, 32'd5);
        drain(4);

        // three-way contention from pointer 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        push(0, 4'd2, 32'h20); push(1, 4'd3, 32'h30); push(2, 4'd4, 32'h40);
        drain(6);

        // back-to-back stream, no contention
        push(2, 4'd5, 32'h55); push(2, 4'd6, 32'h66); push(2, 4'd7, 32'h77);
        drain(6);

        // continuous unit 0 against a single unit 1 result
        for (int k = 0; k < 6; k++) push(0, 4'(10 + k), 32'(100 + k));
        push(1, 4'd9, 32'd50);
        drain(12);

        // flush with two full slots and a fresh input on unit 2
        push(0, 4'd10, 32'hA0); push(1, 4'd11, 32'hB0);
        tick();
        push(2, 4'd12, 32'hC0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(4);

        // reset with two full slots, then an illegal tag-0 result
        push(0, 4'd13, 32'hD0); push(1, 4'd14, 32'hE0);
        drain(2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        push(1, 4'd0, 32'hBAD);
        drain(4);

        // randomized traffic with occasional flush/reset and illegal tags
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() < 2 && $urandom_range(0, 99) < 45)
                    push(i, 4'($urandom_range(0, 15)), $urandom);
            end
            flush = ($urandom_range(0, 99) < 3);
            reset = !($urandom_range(0, 99) < 2);
            tick();
        end
        flush = 1'b0;
        reset = 1'b1;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) among the functional-unit result ports: ST_LD unit, ALU, multiplier.
- Each unit hands its finished result (ROB tag, value) to a one-entry holding slot inside this block.
- A round-robin arbiter picks one occupied slot per cycle and drives it onto the registered `cdb` output.
- `cdb` feeds the ST_LD and ALU reservation stations, the ROB and the map table.

## Interface
Parameters:
- `NUM_FU`, 3: number of result requesters.
- `TAG_W`, 4: ROB tag width, matching the RS `alloc_slot` width. Tag 0 is reserved for "no tag / idle".
- `DATA_W`, 32: result value width.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low; 0 at a rising edge resets the block.
- `flush` input 1: squash all held results, e.g. on mispredict recovery.
- `fu_valid` input [NUM_FU]: unit i presents a result this cycle.
- `fu_tag` input [NUM_FU][TAG_W]: ROB tag of unit i's result.
- `fu_value` input [NUM_FU][DATA_W]: value of unit i's result.
- `fu_ready` output [NUM_FU]: slot i can accept this cycle (combinational).
- `cdb` output CDB_DATA {rob_tag, value}: registered broadcast. `rob_tag` = 0 means nothing is broadcast.
- `cdb_grant` output [NUM_FU]: registered, one-hot; the source of the current `cdb`, all-zero when idle.

## Operation
- Per-unit slot: `slot_v[i]`, `slot_tag[i]`, `slot_val[i]`.
- `fu_ready[i] = !slot_v[i] || grant[i]`. A slot granted this cycle may be refilled at the same edge.
- Capture: at the edge, if `fu_valid[i] && fu_ready[i] && fu_tag[i] != 0`, load slot i.
- `fu_valid` with tag 0 is illegal and is discarded; the slot is not loaded.
- Arbitration (combinational):
  - Candidates are the slots with `slot_v` set.
  - Priority search starts at pointer `rr_ptr` and proceeds i, i+1, … mod NUM_FU.
  - At most one grant per cycle.
- On grant to i, at the edge:
  - `cdb` <= {slot_tag[i], slot_val[i]}; `cdb_grant` <= onehot(i).
  - Slot i clears, unless it is reloaded at the same edge.
  - `rr_ptr` <= (i+1) mod NUM_FU.
- No grant: `cdb` <= 0, `cdb_grant` <= 0, `rr_ptr` unchanged.
- Fairness: a held result is broadcast within NUM_FU cycles of capture.
- `flush`, priority over everything except reset:
  - All slots cleared; `cdb` <= 0; `cdb_grant` <= 0.
  - Inputs presented that cycle are discarded.
  - `rr_ptr` is kept.
  - `fu_ready` is forced to 0 while `flush` = 1.
- Reset state: all slots empty; `cdb` = 0; `cdb_grant` = 0; `rr_ptr` = 0. While `reset` = 0, `fu_ready` = 0.

## Timing
- Latency: a result captured at edge E0 appears on `cdb` at E1 at the earliest, if it wins immediately. It appears at E0 + k, with k ≤ NUM_FU, under contention.
- `cdb` is stable for exactly one cycle per broadcast. Consumers sample it at the following edge.
- A unit that is continuously valid and never contended sustains one result per cycle: its slot is granted and refilled at the same edge.
- A unit whose `fu_ready` = 0 must hold `fu_valid`, `fu_tag` and `fu_value` stable until ready.
- Reset or flush in mid-operation takes effect at that edge. The next broadcast can occur no earlier than one edge after the first capture following release.

## Structure
- Shared package (existing sys_defs): `CDB_DATA` {rob_tag, value}, the tag/data width constants, and new typedef `FU_RESULT` {valid, rob_tag, value}.
- Sub-module `rr_arbiter`: purely combinational.
  - Parameter `N`; inputs `req[N]` and `ptr`; output one-hot `grant[N]`.
  - Reused later for RS issue selection.
- `cdb_arbiter` holds the slots, the pointer and the output registers.

## Test plan
- After reset release, unit 0 presents {tag 1, value 5} for one cycle → next cycle `cdb` = {1, 5}, `cdb_grant` = 001, then `cdb` = 0.
- Units 0, 1, 2 present tags 2, 3, 4 in the same cycle, `rr_ptr` = 0 → broadcasts 2, 3, 4 on three consecutive cycles. All three `fu_ready` are 0 until each slot's own grant.
- Unit 2 back-to-back valid with tags 5, 6, 7 and no contention → `cdb` shows 5, 6, 7 on consecutive cycles with no bubbles.
- Unit 0 continuously valid plus unit 1 with one result (tag 9, value 50) → tag 9 broadcast within 2 cycles; afterwards the units alternate. Unit 0 is never granted twice in a row while unit 1 holds a result.
- Slots 0 and 1 full, `flush` asserted for one cycle together with a new `fu_valid` on unit 2 → no broadcast of any of the three; `cdb` = 0 the following cycle.
- `reset` = 0 for one edge while two slots are full → `cdb` = 0, all slots empty, `rr_ptr` = 0. A `fu_valid` with tag 0 after release → no capture, `cdb` stays 0.
